// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped L1 data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_pkg;

  // Byte offset within a 32-byte line and word select within that line
  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;
  localparam int WORD_W     = 32;

  // Tag field sized for the widest tag a 32-bit address can produce;
  // narrower tags are zero-extended into it
  localparam int TAG_MAX_W  = 32 - OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_RD     = 2'd2,
    ST_REFILL = 2'd3
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle of the data cache controller.
// Latency: n/a (wiring only).
// Backpressure: cpu_stall_o toward the pipeline, mem_ack_i from memory.
interface dcache_ctrl_if #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 256
);

  logic [ADDR_W-1:0]    cpu_addr_i;
  logic [31:0]          cpu_data_i;
  logic                 cpu_MemRead_i;
  logic                 cpu_MemWrite_i;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;

  // Cache controller side
  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o,
    output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

  // Pipeline / memory environment side
  modport master (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
  );

endinterface

// File: rtl/dcache_sram.sv
// Tag (valid/dirty/tag) and data storage for the direct-mapped cache.
// Latency: combinational read by index, writes take effect at the next clock edge.
// Backpressure: none; the controller never fills and stores in the same cycle.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int LINE_BITS = 256,
  parameter int TAG_W     = 23,
  parameter int IDX_W     = $clog2(NUM_SETS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      idx,
  output tag_entry_t            entry,
  output logic [LINE_BITS-1:0]  line,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_BITS-1:0]  fill_line,
  input  logic                  store_en,
  input  logic [WORD_SEL_W-1:0] store_sel,
  input  logic [WORD_W-1:0]     store_data
);

  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];

  // Valid/dirty bits: cleared by reset, set by refill, dirtied by a store hit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (store_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; their contents are meaningless until valid
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (store_en) begin
      data_q[idx][int'(store_sel) * WORD_W +: WORD_W] <= store_data;
    end
  end

  // Combinational read port shared by lookup, write-back and fill
  always_comb begin
    entry.valid = valid_q[idx];
    entry.dirty = dirty_q[idx];
    entry.tag   = TAG_MAX_W'(tag_q[idx]);
    line        = data_q[idx];
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller.
// Latency: hits are zero-latency; a miss stalls through write-back, refill and one REFILL cycle.
// Backpressure: cpu_stall_o freezes the pipeline; memory transfers complete on mem_ack_i.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFFSET_W;

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] WB     = ST_WB;
  localparam logic [1:0] RD     = ST_RD;
  localparam logic [1:0] REFILL = ST_REFILL;

  logic [1:0]            state_q;
  logic [IDX_W-1:0]      miss_idx_q;
  logic [TAG_W-1:0]      miss_tag_q;

  logic [IDX_W-1:0]      cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [WORD_SEL_W-1:0] word_sel;
  logic [IDX_W-1:0]      sram_idx;
  logic [TAG_W-1:0]      victim_tag;
  logic                  req;
  logic                  is_store;
  logic                  in_idle;
  logic                  hit;
  logic                  miss;
  logic                  store_en;
  logic                  fill_en;
  tag_entry_t            entry;
  logic [LINE_BITS-1:0]  line;

  logic [31:0]           cpu_data;
  logic                  cpu_stall;
  logic                  mem_enable;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_addr;
  logic [LINE_BITS-1:0]  mem_data;

  // Word alignment is guaranteed by the pipeline, so the low address bits are dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  assign cpu_idx  = bus.cpu_addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
  assign cpu_tag  = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign word_sel = bus.cpu_addr_i[OFFSET_W-1:2];
  assign req      = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign is_store = bus.cpu_MemWrite_i;
  assign in_idle  = (state_q == IDLE);

  // While a miss is outstanding the arrays are addressed by the latched index
  assign sram_idx   = in_idle ? cpu_idx : miss_idx_q;
  assign victim_tag = entry.tag[TAG_W-1:0];

  assign hit      = req & entry.valid & (entry.tag == TAG_MAX_W'(cpu_tag));
  assign miss     = in_idle & req & ~hit;
  assign store_en = in_idle & hit & is_store;
  assign fill_en  = (state_q == RD) & bus.mem_ack_i;

  dcache_sram #(
    .NUM_SETS  (NUM_SETS),
    .LINE_BITS (LINE_BITS),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx        (sram_idx),
    .entry      (entry),
    .line       (line),
    .fill_en    (fill_en),
    .fill_tag   (miss_tag_q),
    .fill_line  (bus.mem_data_i),
    .store_en   (store_en),
    .store_sel  (word_sel),
    .store_data (bus.cpu_data_i)
  );

  // Miss FSM: latch the missing index/tag, optionally write back the victim, then refill
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            miss_idx_q <= cpu_idx;
            miss_tag_q <= cpu_tag;
            state_q    <= (entry.valid & entry.dirty) ? WB : RD;
          end
        end
        WB:      if (bus.mem_ack_i) state_q <= RD;
        RD:      if (bus.mem_ack_i) state_q <= REFILL;
        REFILL:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode; memory-side values depend only on registered state so they hold until ack
  always_comb begin
    cpu_data   = '0;
    cpu_stall  = 1'b0;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    case (state_q)
      IDLE: begin
        cpu_stall = miss;
        if (hit && !is_store) begin
          cpu_data = line[int'(word_sel) * WORD_W +: WORD_W];
        end
      end
      WB: begin
        cpu_stall  = 1'b1;
        mem_enable = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {victim_tag, miss_idx_q, {OFFSET_W{1'b0}}};
        mem_data   = line;
      end
      RD: begin
        cpu_stall  = 1'b1;
        mem_enable = 1'b1;
        mem_addr   = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
      end
      REFILL: begin
        cpu_stall = 1'b1;
      end
      default: begin
        cpu_stall = 1'b0;
      end
    endcase
    // A pending request must not hold the pipeline frozen while reset is asserted
    if (rst_i) begin
      cpu_stall = 1'b0;
    end
  end

  assign bus.cpu_data_o   = cpu_data;
  assign bus.cpu_stall_o  = cpu_stall;
  assign bus.mem_enable_o = mem_enable;
  assign bus.mem_write_o  = mem_write;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = mem_data;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios followed by random loads/stores.
// Expected data comes from a flat word-memory view; hit/write-back expectations from a tag model.
module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int lat   = 3;

  // Tag-level cache model: which line each set holds and whether it was written
  bit          mv [16];
  bit          md [16];
  logic [22:0] mt [16];

  // Backing memory lines (written by write-backs) and the latest stored word values
  logic [255:0] backing [int unsigned];
  logic [31:0]  shadow  [int unsigned];

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;
  txn_t log_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0]  la;
    logic [255:0] l;
    la = a & ~32'h1F;
    if (backing.exists(la)) begin
      l = backing[la];
      return l[int'(a[4:2]) * 32 +: 32];
    end
    return pattern(a);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return mem_word(a);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = exp_word(la + 32'(w * 4));
    return l;
  endfunction

  // Reset drops every dirty line; those words fall back to what memory holds
  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      if (mv[s] && md[s]) begin
        for (int w = 0; w < 8; w++) begin
          shadow.delete({mt[s], 4'(s), 5'b0} + 32'(w * 4));
        end
      end
      mv[s] = 1'b0;
      md[s] = 1'b0;
    end
  endtask

  // Memory responder: acks each request after 'lat' enabled cycles, logs every transfer
  initial begin
    int          cnt;
    logic [31:0] a0;
    cnt = 0;
    a0  = '0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (rst || bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0;
        cnt = 0;
      end else if (bus.mem_enable_o) begin
        if (cnt == 0) a0 = bus.mem_addr_o;
        else check("mem_addr_stable", bus.mem_addr_o, a0);
        cnt++;
        if (cnt >= lat) begin
          bus.mem_ack_i = 1'b1;
          if (bus.mem_write_o) backing[bus.mem_addr_o] = bus.mem_data_o;
          else bus.mem_data_i = mem_line(bus.mem_addr_o);
          log_q.push_back('{bus.mem_write_o, bus.mem_addr_o, bus.mem_data_o});
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One CPU access held until the stall clears; it retires on the following rising edge
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input string nm);
    logic [3:0]   set;
    logic [22:0]  tg;
    bit           exp_hit, exp_wb;
    logic [31:0]  wb_addr;
    logic [255:0] wb_line;
    int           cyc, exp_cyc, n;
    set     = addr[8:5];
    tg      = addr[31:9];
    exp_hit = mv[set] && (mt[set] == tg);
    exp_wb  = !exp_hit && mv[set] && md[set];
    wb_addr = '0;
    wb_line = '0;
    if (exp_wb) begin
      wb_addr = {mt[set], set, 5'b0};
      wb_line = exp_line(wb_addr);
    end
    exp_cyc = exp_hit ? 0 : (exp_wb ? 2 * lat + 3 : lat + 2);
    log_q.delete();
    @(negedge clk);
    bus.cpu_addr_i     = addr;
    bus.cpu_data_i     = data;
    bus.cpu_MemRead_i  = rd;
    bus.cpu_MemWrite_i = wr;
    #1;
    check({nm, "_stall0"}, bus.cpu_stall_o, !exp_hit);
    cyc = 0;
    while (bus.cpu_stall_o && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({nm, "_stall_cycles"}, cyc, exp_cyc);
    if (rd && !wr) check({nm, "_data"}, bus.cpu_data_o, exp_word(addr));
    check({nm, "_en_idle"}, bus.mem_enable_o, 1'b0);
    n = exp_hit ? 0 : (exp_wb ? 2 : 1);
    check({nm, "_ntxn"}, log_q.size(), n);
    if (log_q.size() == n && n > 0) begin
      if (exp_wb) begin
        check({nm, "_wb_wr"}, log_q[0].wr, 1'b1);
        check({nm, "_wb_addr"}, log_q[0].addr, wb_addr);
        check({nm, "_wb_line"}, log_q[0].data, wb_line);
      end
      check({nm, "_rd_wr"}, log_q[n-1].wr, 1'b0);
      check({nm, "_rd_addr"}, log_q[n-1].addr, addr & ~32'h1F);
    end
    if (!exp_hit) begin
      mv[set] = 1'b1;
      mt[set] = tg;
      md[set] = 1'b0;
    end
    if (wr) begin
      md[set]      = 1'b1;
      shadow[addr] = data;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.cpu_MemRead_i  = 1'b0;
      bus.cpu_MemWrite_i = 1'b0;
      bus.cpu_addr_i     = $urandom & ~32'h3;
      #1;
      check("idle_data", bus.cpu_data_o, 32'h0);
      check("idle_stall", bus.cpu_stall_o, 1'b0);
      check("idle_en", bus.mem_enable_o, 1'b0);
    end
  endtask

  initial begin
    logic [255:0] l;
    rst = 1'b1;
    bus.cpu_addr_i     = '0;
    bus.cpu_data_i     = '0;
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    for (int s = 0; s < 16; s++) begin
      mv[s] = 1'b0;
      md[s] = 1'b0;
      mt[s] = '0;
    end
    l = mem_line(32'h100);
    l[63:32] = 32'hDEAD_BEEF;
    backing[32'h100] = l;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", bus.cpu_stall_o, 1'b0);
    check("rst_en", bus.mem_enable_o, 1'b0);
    check("rst_wr", bus.mem_write_o, 1'b0);
    check("rst_addr", bus.mem_addr_o, 32'h0);
    check("rst_mdata", bus.mem_data_o, 256'h0);
    check("rst_cdata", bus.cpu_data_o, 32'h0);
    #1 rst = 1'b0;

    // Cold read miss with a slow memory
    lat = 10;
    access(1'b1, 1'b0, 32'h104, 32'h0, "cold_rd");
    lat = 2;
    // Hits across the whole filled line
    for (int w = 0; w < 8; w++) access(1'b1, 1'b0, 32'h100 + 32'(w * 4), 32'h0, "hit_rd");
    // Store hit, then a conflicting load evicts the dirty line
    access(1'b0, 1'b1, 32'h108, 32'h1234_5678, "st_hit");
    access(1'b1, 1'b0, 32'h2108, 32'h0, "dirty_evict");
    check("evict_word2", mem_word(32'h108), 32'h1234_5678);
    // Store miss on a clean set, then prove the line became dirty
    access(1'b0, 1'b1, 32'h3000, 32'hAAAA_0001, "st_miss");
    access(1'b1, 1'b0, 32'h3000, 32'h0, "st_miss_rd");
    access(1'b1, 1'b0, 32'h1000, 32'h0, "st_miss_evict");
    check("evict_word0", mem_word(32'h3000), 32'hAAAA_0001);
    // Read and write together on a hit behaves as a store
    access(1'b1, 1'b1, 32'h1004, 32'h55AA_33CC, "rdwr_hit");
    access(1'b1, 1'b0, 32'h1004, 32'h0, "rdwr_rd");
    access(1'b1, 1'b0, 32'h3004, 32'h0, "rdwr_evict");
    check("rdwr_mem", mem_word(32'h1004), 32'h55AA_33CC);
    idle(2);

    // Reset while a refill is outstanding
    lat = 50;
    log_q.delete();
    @(negedge clk);
    bus.cpu_addr_i    = 32'h4060;
    bus.cpu_MemRead_i = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("midrd_en", bus.mem_enable_o, 1'b1);
    check("midrd_addr", bus.mem_addr_o, 32'h4060);
    #1 rst = 1'b1;
    #1;
    check("midrd_rst_en", bus.mem_enable_o, 1'b0);
    check("midrd_rst_stall", bus.cpu_stall_o, 1'b0);
    check("midrd_rst_addr", bus.mem_addr_o, 32'h0);
    model_reset();
    @(negedge clk);
    bus.cpu_MemRead_i = 1'b0;
    #2 rst = 1'b0;
    lat = 3;
    access(1'b1, 1'b0, 32'h4060, 32'h0, "rst_reload");
    access(1'b1, 1'b0, 32'h104, 32'h0, "rst_cold");

    // Random traffic over a few tags per set to force conflicts and evictions
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int          op;
      a   = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5)
          | (32'($urandom_range(0, 7)) << 2);
      op  = $urandom_range(0, 3);
      lat = $urandom_range(1, 5);
      access(op != 2, op >= 2, a, $urandom, "rnd");
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
